softmax_max_stage: RTL and testbench
====================================

# softmax_max_stage

Upstream front end of the softmax datapath. Buffers one vector of VECLEN IEEE-754 single-precision scores and finds the vector maximum. It then streams each score back out, paired with the negated maximum, so the next stage (a float adder feeding the exponential unit) forms x_i − max. The subtraction keeps every exponential argument ≤ 0 and inside the Taylor-series range of the exponential unit.

## Interface
- BITWIDTH, 32, word width; only 32 (float32) is supported.
- VECLEN, 8, scores per vector; must be ≥ 2.
- ADDRW, 3, buffer index width; must satisfy 2^ADDRW ≥ VECLEN.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InValid  in  1  Datain holds a valid score.
- Datain  in  BITWIDTH  input score, float32.
- InReady  out  1  stage accepts a score this cycle.
- OutValid  out  1  DataOut/MaxNeg/OutLast are valid.
- OutReady  in  1  downstream accepts the output this cycle.
- DataOut  out  BITWIDTH  buffered score x_i, in arrival order.
- MaxNeg  out  BITWIDTH  −max of the current vector (max with the sign bit inverted).
- OutLast  out  1  marks the last element (index VECLEN−1) of a vector.

## Operation
- Two states: LOAD and DRAIN. Reset enters LOAD with index 0.
- In LOAD:
  - InReady = 1 and OutValid = 0.
  - On InValid & InReady, Datain is written to buf[idx].
  - Running max: element 0 is loaded unconditionally. Each later element replaces the max only if it is strictly greater, so on ties the first occurrence wins.
  - When idx = VECLEN−1 is accepted: idx ← 0, state ← DRAIN.
- In DRAIN:
  - InReady = 0 and OutValid = 1.
  - DataOut = buf[idx], MaxNeg = {~max[31], max[30:0]}, OutLast = (idx == VECLEN−1).
  - On OutValid & OutReady, idx increments. When the last element is accepted: idx ← 0, state ← LOAD.
  - While OutReady = 0, all outputs hold stable.
- Float compare uses an order key: key = x[31] ? ~x : x ^ 32'h80000000. The larger unsigned key is the larger value.
  - Consequence: +0 (00000000) ranks above −0 (80000000).
  - NaN inputs are not supported. Their ordering follows the key with no special casing.
- No arithmetic is performed on mantissa or exponent. MaxNeg is a sign-bit flip only.
- There is no overlap between vectors: inputs are refused for the whole drain.

## Timing
- Reset values: InReady = 0 while Reset is low, then 1 from the first cycle after release. OutValid = 0, DataOut = 0, MaxNeg = 0, OutLast = 0. Internal: state = LOAD, idx = 0, max = 0.
- One score is accepted per cycle at full rate. A vector takes VECLEN accepting edges.
- OutValid rises the cycle right after the edge that accepts the last input. DataOut = buf[0] in that cycle.
- Outputs come from registers and the buffer read, with no combinational path from Datain. Fill-to-drain latency is 1 cycle.
- With OutReady held high, a full drain takes VECLEN cycles. Once it completes, InReady is 1 in the next cycle.
- The minimum period per vector is 2·VECLEN cycles.
- Gaps in InValid stall LOAD without losing the index or the running max.
- Reset asserted mid-LOAD or mid-DRAIN:
  - The partial vector and max are discarded and all outputs go to reset values immediately (asynchronous reset).
  - After release, loading restarts at index 0.

## Test plan
- Fill: VECLEN=8, inputs 3f800000, 40000000, c0400000, 3f000000, 40800000, bf000000, 00000000, 3f800000 → DataOut returns the same 8 words in order, MaxNeg = c0800000 on every beat, OutLast only on beat 8, OutValid asserted 1 cycle after the 8th accept.
- All negative: 8 inputs alternating bf800000 and bf000000 → MaxNeg = 3f000000.
- Signed zero and ties: inputs 80000000, 00000000, then six copies of 80000000 → max = 00000000, MaxNeg = 80000000. Separately, eight inputs of 40000000 → MaxNeg = c0000000.
- Backpressure: during DRAIN, toggle OutReady 1,0,0,1 → each word appears exactly once, outputs stay stable while stalled, InReady stays 0 until the last word is accepted.
- Input gaps: InValid high every other cycle during LOAD → same output as the Fill case; DRAIN begins 1 cycle after the 8th accept.
- Mid-operation reset: pull Reset low after 5 accepts, release it, then load a fresh vector whose max is 3f000000 → MaxNeg = bf000000, with no data from the discarded partial vector reaching the output.

Source files
------------

// File: rtl/softmax_max_stage.sv
// softmax_max_stage: buffers one vector of float32 scores, tracks the vector
// maximum while loading, then replays each score paired with -max so the
// downstream adder can form x_i - max.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accepting scores into the buffer, updating the running max
// ST_DRAIN | replaying buffered scores with -max, inputs refused
module softmax_max_stage #(
   parameter int BITWIDTH = 32,
   parameter int VECLEN   = 8,
   parameter int ADDRW    = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                InValid,
   input  logic [BITWIDTH-1:0] Datain,
   output logic                InReady,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [BITWIDTH-1:0] DataOut,
   output logic [BITWIDTH-1:0] MaxNeg,
   output logic                OutLast
);

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(VECLEN - 1);

   state_t              state;
   state_t              state_nxt;
   logic [ADDRW-1:0]    idx;
   logic                run;
   logic                accept;
   logic                advance;
   logic                at_last;
   logic [BITWIDTH-1:0] max_val;
   logic [BITWIDTH-1:0] score_buf [VECLEN];

   // Maps float32 onto an unsigned ordering: negatives are fully inverted so
   // larger magnitude sorts lower; positives get the sign bit set so they sort
   // above all negatives. +0 therefore ranks above -0.
   function automatic logic [BITWIDTH-1:0] order_key(input logic [BITWIDTH-1:0] x);
      logic [BITWIDTH-1:0] key;
      if (x[BITWIDTH-1]) begin
         key = ~x;
      end else begin
         key = x ^ {1'b1, {(BITWIDTH-1){1'b0}}};
      end
      return key;
   endfunction

   assign at_last = (idx == LAST_IDX);

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Holds InReady low while in reset and lets it rise on the first edge after release
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      OutValid  = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_LOAD: begin
            InReady = run;
            accept  = InValid & run;
            if (accept && at_last) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            OutValid = 1'b1;
            advance  = OutReady;
            if (advance && at_last) begin
               state_nxt = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
   end

   // Shared index: write pointer while loading, read pointer while draining
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         idx <= '0;
      end else if (accept || advance) begin
         if (at_last) begin
            idx <= '0;
         end else begin
            idx <= idx + ADDRW'(1);
         end
      end
   end

   // Running max; element 0 seeds it, later elements win only when strictly greater
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         max_val <= '0;
      end else if (accept) begin
         if ((idx == '0) || (order_key(Datain) > order_key(max_val))) begin
            max_val <= Datain;
         end
      end
   end

   // Score buffer; contents are don't-care until written, outputs are gated below
   always_ff @(posedge Clock) begin
      if (accept) begin
         score_buf[idx] <= Datain;
      end
   end

   // Output data is forced to zero whenever no beat is being presented
   always_comb begin
      DataOut = '0;
      MaxNeg  = '0;
      OutLast = 1'b0;
      if (OutValid) begin
         DataOut = score_buf[idx];
         MaxNeg  = {~max_val[BITWIDTH-1], max_val[BITWIDTH-2:0]};
         OutLast = at_last;
      end
   end

endmodule

// File: tb/tb_softmax_max_stage.sv
// Self-checking bench for softmax_max_stage: directed vectors from the test
// plan plus randomized vectors, checked against a sign/magnitude max model.
module tb_softmax_max_stage;

   localparam int VL = 8;
   typedef logic [31:0] vec_t [VL];

   logic        Clock;
   logic        Reset;
   logic        InValid;
   logic [31:0] Datain;
   logic        InReady;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] DataOut;
   logic [31:0] MaxNeg;
   logic        OutLast;

   int vectors    = 0;
   int miscompares = 0;

   softmax_max_stage #(.BITWIDTH(32), .VECLEN(VL), .ADDRW(3)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .InValid (InValid),
      .Datain  (Datain),
      .InReady (InReady),
      .OutValid(OutValid),
      .OutReady(OutReady),
      .DataOut (DataOut),
      .MaxNeg  (MaxNeg),
      .OutLast (OutLast)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // a > b in float order, +0 above -0, NaN never generated
   function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return !a[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   function automatic logic [31:0] ref_max(input vec_t v);
      logic [31:0] m;
      m = v[0];
      for (int i = 1; i < VL; i++) if (fgt(v[i], m)) m = v[i];
      return m;
   endfunction

   function automatic logic [31:0] rand_float();
      logic [31:0] s, e, m;
      s = $urandom_range(0, 1);
      e = $urandom_range(0, 254);
      m = $urandom;
      return {s[0], e[7:0], m[22:0]};
   endfunction

   // gap: 0 none, 1 every other cycle, 2 random
   task automatic send_vec(input vec_t v, input int gap);
      for (int i = 0; i < VL; i++) begin
         if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
            InValid = 1'b0;
            Datain  = $urandom;
            @(negedge Clock);
            vectors++;
            if (InReady !== 1'b1 || OutValid !== 1'b0) begin
               miscompares++;
               $display("FAIL load_gap idx=%0d: InReady=%b OutValid=%b, want 1 0", i, InReady, OutValid);
            end
         end
         InValid = 1'b1;
         Datain  = v[i];
         vectors++;
         if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_handshake idx=%0d: InReady=%b OutValid=%b, want 1 0", i, InReady, OutValid);
         end
         @(negedge Clock);
      end
      InValid = 1'b0;
      Datain  = '0;
   endtask

   // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random
   task automatic drain_vec(input vec_t v, input int mode);
      logic [31:0] exp_neg;
      logic        pat [4];
      int          b;
      int          k;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_neg = ref_max(v) ^ 32'h8000_0000;
      b = 0;
      k = 0;
      while (b < VL && k < 200) begin
         vectors++;
         if (OutValid !== 1'b1 || InReady !== 1'b0 || DataOut !== v[b] ||
             MaxNeg !== exp_neg || OutLast !== 1'(b == VL - 1)) begin
            miscompares++;
            $display("FAIL drain_beat %0d: OutValid=%b InReady=%b DataOut=%h MaxNeg=%h OutLast=%b, want 1 0 %h %h %b",
                     b, OutValid, InReady, DataOut, MaxNeg, OutLast, v[b], exp_neg, (b == VL - 1));
         end
         if (mode == 0) OutReady = 1'b1;
         else if (mode == 1) OutReady = pat[k % 4];
         else OutReady = 1'($urandom_range(0, 1));
         @(negedge Clock);
         if (OutReady) b++;
         k++;
      end
      OutReady = 1'b0;
      vectors++;
      if (b != VL) begin
         miscompares++;
         $display("FAIL drain_timeout: beats=%0d, want %0d", b, VL);
      end
      vectors++;
      if (OutValid !== 1'b0 || InReady !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_done: OutValid=%b InReady=%b, want 0 1", OutValid, InReady);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if (InReady !== 1'b0 || OutValid !== 1'b0 || DataOut !== 32'h0 ||
          MaxNeg !== 32'h0 || OutLast !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: InReady=%b OutValid=%b DataOut=%h MaxNeg=%h OutLast=%b, want all 0",
                  tag, InReady, OutValid, DataOut, MaxNeg, OutLast);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check_reset_outputs("reset_hold");
      Reset = 1'b1;
      @(negedge Clock);
      vectors++;
      if (InReady !== 1'b1 || OutValid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: InReady=%b OutValid=%b, want 1 0", InReady, OutValid);
      end
   endtask

   task automatic test_fill();
      vec_t v;
      v = '{32'h3f800000, 32'h40000000, 32'hc0400000, 32'h3f000000,
            32'h40800000, 32'hbf000000, 32'h00000000, 32'h3f800000};
      vectors++;
      if ((ref_max(v) ^ 32'h8000_0000) !== 32'hc0800000) begin
         miscompares++;
         $display("FAIL fill_model: got %h, want c0800000", ref_max(v) ^ 32'h8000_0000);
      end
      send_vec(v, 0);
      drain_vec(v, 0);
   endtask

   task automatic test_all_negative();
      vec_t v;
      for (int i = 0; i < VL; i++) v[i] = (i % 2 == 0) ? 32'hbf800000 : 32'hbf000000;
      send_vec(v, 0);
      drain_vec(v, 0);
   endtask

   task automatic test_signed_zero_ties();
      vec_t v;
      v[0] = 32'h80000000;
      v[1] = 32'h00000000;
      for (int i = 2; i < VL; i++) v[i] = 32'h80000000;
      send_vec(v, 0);
      drain_vec(v, 0);
      for (int i = 0; i < VL; i++) v[i] = 32'h40000000;
      send_vec(v, 0);
      drain_vec(v, 0);
   endtask

   task automatic test_backpressure();
      vec_t v;
      for (int i = 0; i < VL; i++) v[i] = rand_float();
      send_vec(v, 0);
      drain_vec(v, 1);
   endtask

   task automatic test_gaps();
      vec_t v;
      v = '{32'h3f800000, 32'h40000000, 32'hc0400000, 32'h3f000000,
            32'h40800000, 32'hbf000000, 32'h00000000, 32'h3f800000};
      send_vec(v, 1);
      drain_vec(v, 0);
   endtask

   task automatic test_mid_reset();
      vec_t v;
      vec_t junk;
      for (int i = 0; i < VL; i++) junk[i] = 32'h42000000 + i;
      for (int i = 0; i < 5; i++) begin
         InValid = 1'b1;
         Datain  = junk[i];
         @(negedge Clock);
      end
      InValid = 1'b0;
      #2 Reset = 1'b0;
      #1 check_reset_outputs("reset_mid_load");
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      v = '{32'h3e800000, 32'hbf800000, 32'h3f000000, 32'h00000000,
            32'h3e000000, 32'hc0000000, 32'h3f000000, 32'h80000000};
      send_vec(v, 0);
      drain_vec(v, 0);
      // reset in the middle of a drain
      send_vec(junk, 0);
      OutReady = 1'b1;
      repeat (3) @(negedge Clock);
      #2 Reset = 1'b0;
      #1 check_reset_outputs("reset_mid_drain");
      OutReady = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      send_vec(v, 0);
      drain_vec(v, 0);
   endtask

   task automatic test_back_to_back();
      vec_t v1;
      vec_t v2;
      for (int i = 0; i < VL; i++) begin
         v1[i] = rand_float();
         v2[i] = rand_float();
      end
      send_vec(v1, 0);
      drain_vec(v1, 0);
      send_vec(v2, 0);
      drain_vec(v2, 0);
   endtask

   task automatic test_random();
      vec_t v;
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < VL; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) v[i] = v[$urandom_range(0, i - 1)];
            else if ($urandom_range(0, 7) == 0) v[i] = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h0;
            else v[i] = rand_float();
         end
         send_vec(v, 2);
         drain_vec(v, 2);
      end
   endtask

   initial begin
      Reset    = 1'b0;
      InValid  = 1'b0;
      Datain   = '0;
      OutReady = 1'b0;
      test_reset();
      test_fill();
      test_all_negative();
      test_signed_zero_ties();
      test_backpressure();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
